stopwatch_counter: RTL and testbench
====================================

// Module: stopwatch_counter
// PURPOSE
//   MM:SS stopwatch time-keeping core, directly downstream of the clock divider.
//   - Consumes the divider's toggling clk_1hz / clk_2hz levels as tick sources (sampled in the clk domain).
//   - Runs, pauses, or is manually adjusted.
//   - Presents four BCD digits plus per-field blink masks to the 7-segment display stage.
// PARAMETERS
//   SYNC_STAGES  2   flop stages synchronising sel/adj/pause_btn (>=2)
//   SEC_MOD      60  seconds modulus (count 0..SEC_MOD-1)
//   MIN_MOD      60  minutes modulus (count 0..MIN_MOD-1)
// PORTS
//   clk        in   1  system clock (100 MHz)
//   rst        in   1  synchronous, active-high reset
//   clk_1hz_in in   1  divider 1 Hz toggle level; rising edge = run tick
//   clk_2hz_in in   1  divider 2 Hz toggle level; rising edge = adjust tick / blink toggle
//   sel        in   1  adjust field select: 0 = seconds, 1 = minutes (async switch)
//   adj        in   1  adjust mode enable (async switch)
//   pause_btn  in   1  debounced pause button level (async)
//   min_tens   out  4  BCD minutes tens
//   min_ones   out  4  BCD minutes ones
//   sec_tens   out  4  BCD seconds tens
//   sec_ones   out  4  BCD seconds ones
//   paused     out  1  1 = run count frozen
//   blink_min  out  1  1 = display blanks minute digits this cycle
//   blink_sec  out  1  1 = display blanks second digits this cycle
// BEHAVIOUR
//   Reset
//   - Synchronous, active-high. All digits 0, paused=0, blink_*=0, blink phase=0, state RUN.
//   - Synchroniser flops and edge-detect history regs load their current input during reset.
//     Consequence: an input already high at reset release produces no edge.
//   - rst asserted mid-count or mid-adjust wins over any tick in the same cycle.
//   Input conditioning
//   - sel/adj/pause_btn pass through SYNC_STAGES flops.
//   - clk_*_in are same-domain and are not synchronised.
//   - Edge pulse: in & ~prev.
//   - One cycle of latency from an input rise (post-sync) to the output update.
//   States
//   - ADJUST: whenever adj_s=1. Takes precedence over everything else.
//   - Otherwise RUN or PAUSED, selected by the paused flag.
//   - pause_btn rise in RUN -> PAUSED; in PAUSED -> RUN.
//   - pause_btn rise in ADJUST is ignored; paused is held.
//   - Leaving ADJUST returns to RUN or PAUSED per the held paused flag.
//   RUN
//   - On a 1 Hz edge, seconds +1.
//   - At SEC_MOD-1: seconds->0 and minutes +1.
//   - At MIN_MOD-1:SEC_MOD-1: wraps to 00:00. No overflow flag.
//   - 2 Hz edges are ignored in RUN.
//   PAUSED
//   - All digits hold; ticks are ignored.
//   ADJUST
//   - On a 2 Hz edge, the selected field +1 mod its modulus.
//   - No carry into the other field.
//   - 1 Hz edges are ignored (the 1 Hz edge coincides with a 2 Hz edge; only one increment).
//   - sel change takes effect at the next 2 Hz edge.
//   - Blink phase toggles on each 2 Hz edge.
//   - blink_sec = adj_s & ~sel_s & phase; blink_min = adj_s & sel_s & phase.
//   - Phase is cleared whenever adj_s=0.
//   Simultaneous events
//   - pause rise + 1 Hz edge in RUN: the tick is counted and paused=1 next cycle.
//   - pause rise + 1 Hz edge in PAUSED: no count; RUN from the next cycle.
//   - adj_s rising in the same cycle as a 1 Hz edge: ADJUST rules apply (no run increment).
//   Arithmetic
//   - Each field is held as two BCD digits.
//   - Ones digit wraps 9->0 with carry into tens.
//   - Field wrap compares the full two-digit value against modulus-1.
//   - Digits never exceed 9; tens never exceed (MOD-1)/10.
// STRUCTURE
//   - stopwatch_pkg: state enum {RUN, PAUSED, ADJUST}, BCD_W=4, default SEC_MOD/MIN_MOD constants.
//   - Sub-module bcd_mod_counter (params MOD) instantiated twice (seconds, minutes):
//     - inputs: clk, rst, inc
//     - outputs: tens, ones, at_max (value == MOD-1)
//     - RUN carry: min inc = sec_inc & sec.at_max.
//   - Top holds synchronisers, edge detectors, FSM, blink phase.
// TESTING
//   1. rst with clk_1hz_in=1 held, then release -> digits 00:00, no increment until the next rise.
//   2. 61 1 Hz rises in RUN -> 01:01. From 59:58, 2 rises -> 00:00.
//   3. pause rise after 5 ticks, 3 more 1 Hz rises, pause rise, 2 rises -> 00:07; paused 1 then 0.
//   4. adj=1, sel=0 from 00:58, 3 2 Hz edges -> 00:01, minutes unchanged.
//      sel=1, 2 edges -> 02:01.
//      blink_sec alternates per 2 Hz edge while sel=0.
//   5. adj=1 with pause rise -> paused unchanged. adj=0 -> resumes prior RUN/PAUSED.
//      blink_* = 0 within SYNC_STAGES+1 cycles.
//   6. rst asserted in the same cycle as a 1 Hz edge at 12:34 -> 00:00 next cycle, no increment.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch core.
package stopwatch_pkg;

    localparam int BCD_W           = 4;
    localparam int SEC_MOD_DEFAULT = 60;
    localparam int MIN_MOD_DEFAULT = 60;

    // Operating mode: ADJUST overrides RUN/PAUSED whenever the adjust switch is on.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_ADJUST = 2'd2
    } state_t;

endpackage

// File: rtl/stopwatch_if.sv
// Tick/switch inputs and display-side outputs of the stopwatch core.
// master = the side driving ticks and switches, slave = the stopwatch core.
interface stopwatch_if;
    import stopwatch_pkg::*;

    logic             clk_1hz_in;
    logic             clk_2hz_in;
    logic             sel;
    logic             adj;
    logic             pause_btn;
    logic [BCD_W-1:0] min_tens;
    logic [BCD_W-1:0] min_ones;
    logic [BCD_W-1:0] sec_tens;
    logic [BCD_W-1:0] sec_ones;
    logic             paused;
    logic             blink_min;
    logic             blink_sec;

    modport master (
        output clk_1hz_in, clk_2hz_in, sel, adj, pause_btn,
        input  min_tens, min_ones, sec_tens, sec_ones, paused, blink_min, blink_sec
    );

    modport slave (
        input  clk_1hz_in, clk_2hz_in, sel, adj, pause_btn,
        output min_tens, min_ones, sec_tens, sec_ones, paused, blink_min, blink_sec
    );

endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter, 0..MOD-1, wrapping to 00 on increment at MOD-1.
module bcd_mod_counter
    import stopwatch_pkg::*;
#(
    parameter int MOD = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones,
    output logic             at_max
);

    // The wrap point is compared as a full two-digit value.
    localparam logic [BCD_W-1:0] MAX_TENS = BCD_W'((MOD - 1) / 10);
    localparam logic [BCD_W-1:0] MAX_ONES = BCD_W'((MOD - 1) % 10);
    localparam logic [BCD_W-1:0] NINE     = BCD_W'(9);
    localparam logic [BCD_W-1:0] ONE      = BCD_W'(1);

    logic [BCD_W-1:0] tens_reg;
    logic [BCD_W-1:0] ones_reg;

    assign at_max = (tens_reg == MAX_TENS) && (ones_reg == MAX_ONES);
    assign tens   = tens_reg;
    assign ones   = ones_reg;

    // Increment with field wrap first, then ones->tens carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            tens_reg <= '0;
            ones_reg <= '0;
        end else if (inc) begin
            if (at_max) begin
                tens_reg <= '0;
                ones_reg <= '0;
            end else if (ones_reg == NINE) begin
                ones_reg <= '0;
                tens_reg <= tens_reg + ONE;
            end else begin
                ones_reg <= ones_reg + ONE;
            end
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch core: synchronises switches, edge-detects the divider
// tick levels, runs/pauses/adjusts two BCD fields and drives blink masks.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int SEC_MOD     = SEC_MOD_DEFAULT,
    parameter int MIN_MOD     = MIN_MOD_DEFAULT
) (
    input  logic      clk,
    input  logic      rst,
    stopwatch_if.slave bus
);

    // Bit order in the synchroniser: {pause_btn, adj, sel}
    logic [2:0] raw_in;
    logic [2:0] sync_reg [SYNC_STAGES];
    logic       sel_s;
    logic       adj_s;
    logic       pause_s;

    logic       prev_1hz_reg;
    logic       prev_2hz_reg;
    logic       prev_pause_reg;
    logic       edge_1hz;
    logic       edge_2hz;
    logic       pause_rise;

    logic       paused_reg;
    logic       phase_reg;
    state_t     cur_state;

    logic       sec_inc;
    logic       min_inc;
    logic       sec_at_max;
    logic       min_at_max;

    assign raw_in  = {bus.pause_btn, bus.adj, bus.sel};
    assign sel_s   = sync_reg[SYNC_STAGES-1][0];
    assign adj_s   = sync_reg[SYNC_STAGES-1][1];
    assign pause_s = sync_reg[SYNC_STAGES-1][2];

    // Synchroniser chain; every stage preloads the live input during reset
    // so a switch already on at release is not seen as a transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= raw_in;
            end
        end else begin
            sync_reg[0] <= raw_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    // Edge-detect history; loads the current level in reset (no edge at release).
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_1hz_reg   <= bus.clk_1hz_in;
            prev_2hz_reg   <= bus.clk_2hz_in;
            prev_pause_reg <= bus.pause_btn;
        end else begin
            prev_1hz_reg   <= bus.clk_1hz_in;
            prev_2hz_reg   <= bus.clk_2hz_in;
            prev_pause_reg <= pause_s;
        end
    end

    assign edge_1hz   = bus.clk_1hz_in & ~prev_1hz_reg;
    assign edge_2hz   = bus.clk_2hz_in & ~prev_2hz_reg;
    assign pause_rise = pause_s & ~prev_pause_reg;

    // Mode follows adj_s directly so an adjust entry in the same cycle as a
    // 1 Hz edge already suppresses the run increment.
    always_comb begin
        cur_state = ST_RUN;
        if (adj_s) begin
            cur_state = ST_ADJUST;
        end else if (paused_reg) begin
            cur_state = ST_PAUSED;
        end
    end

    // Pause flag and blink phase; the paused flag is held untouched in ADJUST.
    always_ff @(posedge clk) begin
        if (rst) begin
            paused_reg <= 1'b0;
            phase_reg  <= 1'b0;
        end else begin
            case (cur_state)
                ST_RUN: begin
                    if (pause_rise) paused_reg <= 1'b1;
                    phase_reg <= 1'b0;
                end
                ST_PAUSED: begin
                    if (pause_rise) paused_reg <= 1'b0;
                    phase_reg <= 1'b0;
                end
                ST_ADJUST: begin
                    if (edge_2hz) phase_reg <= ~phase_reg;
                end
                default: begin
                    phase_reg <= 1'b0;
                end
            endcase
        end
    end

    // RUN carries seconds into minutes; ADJUST bumps only the selected field.
    always_comb begin
        sec_inc = 1'b0;
        min_inc = 1'b0;
        if (cur_state == ST_RUN) begin
            sec_inc = edge_1hz;
            min_inc = edge_1hz & sec_at_max;
        end else if (cur_state == ST_ADJUST) begin
            sec_inc = edge_2hz & ~sel_s;
            min_inc = edge_2hz & sel_s;
        end
    end

    bcd_mod_counter #(.MOD(SEC_MOD)) u_sec (
        .clk    (clk),
        .rst    (rst),
        .inc    (sec_inc),
        .tens   (bus.sec_tens),
        .ones   (bus.sec_ones),
        .at_max (sec_at_max)
    );

    bcd_mod_counter #(.MOD(MIN_MOD)) u_min (
        .clk    (clk),
        .rst    (rst),
        .inc    (min_inc),
        .tens   (bus.min_tens),
        .ones   (bus.min_ones),
        .at_max (min_at_max)
    );

    // Minutes wrap silently; no overflow indication is produced.
    logic unused_min_at_max;
    assign unused_min_at_max = min_at_max;

    assign bus.paused    = paused_reg;
    assign bus.blink_sec = adj_s & ~sel_s & phase_reg;
    assign bus.blink_min = adj_s &  sel_s & phase_reg;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: reset, run/wrap, pause, adjust,
// adjust-vs-pause interaction and reset racing a tick.
module tb_stopwatch_counter;

    localparam int SS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    stopwatch_if sw_if ();

    stopwatch_counter #(.SYNC_STAGES(SS), .SEC_MOD(60), .MIN_MOD(60)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sw_if.slave)
    );

    always #5 clk = ~clk;

    logic [15:0] mmss;
    assign mmss = {sw_if.min_tens, sw_if.min_ones, sw_if.sec_tens, sw_if.sec_ones};

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick1(input int n);
        for (int i = 0; i < n; i++) begin
            sw_if.clk_1hz_in = 1'b1; cyc(1);
            sw_if.clk_1hz_in = 1'b0; cyc(1);
        end
    endtask

    task automatic tick2(input int n);
        for (int i = 0; i < n; i++) begin
            sw_if.clk_2hz_in = 1'b1; cyc(1);
            sw_if.clk_2hz_in = 1'b0; cyc(1);
        end
    endtask

    task automatic press_pause();
        sw_if.pause_btn = 1'b1; cyc(SS + 2);
        sw_if.pause_btn = 1'b0; cyc(SS + 2);
    endtask

    task automatic do_reset();
        sw_if.clk_1hz_in = 0; sw_if.clk_2hz_in = 0;
        sw_if.sel = 0; sw_if.adj = 0; sw_if.pause_btn = 0;
        rst = 1'b1; cyc(2);
        rst = 1'b0; cyc(1);
    endtask

    task automatic chk_time(input string name, input logic [15:0] exp);
        // single-purpose: only used by the rst-race task below is avoided; inline checks elsewhere
    endtask

    task automatic test_reset();
        sw_if.clk_1hz_in = 1; sw_if.clk_2hz_in = 0;
        sw_if.sel = 0; sw_if.adj = 0; sw_if.pause_btn = 0;
        rst = 1'b1; cyc(3);
        vectors++; if (mmss !== 16'h0000) begin errors++; $display("FAIL reset_digits got=%h exp=%h", mmss, 16'h0000); end else $display("ok   reset_digits %h", mmss);
        vectors++; if ({sw_if.paused, sw_if.blink_min, sw_if.blink_sec} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {sw_if.paused, sw_if.blink_min, sw_if.blink_sec}); end else $display("ok   reset_flags");
        rst = 1'b0; cyc(3);
        vectors++; if (mmss !== 16'h0000) begin errors++; $display("FAIL reset_held_high got=%h exp=%h", mmss, 16'h0000); end else $display("ok   reset_held_high %h", mmss);
        sw_if.clk_1hz_in = 0; cyc(1);
        sw_if.clk_1hz_in = 1; cyc(1);
        vectors++; if (mmss !== 16'h0001) begin errors++; $display("FAIL reset_first_rise got=%h exp=%h", mmss, 16'h0001); end else $display("ok   reset_first_rise %h", mmss);
        sw_if.clk_1hz_in = 0; cyc(1);
    endtask

    task automatic test_run_count();
        do_reset();
        tick1(61);
        vectors++; if (mmss !== 16'h0101) begin errors++; $display("FAIL run_61 got=%h exp=%h", mmss, 16'h0101); end else $display("ok   run_61 %h", mmss);
        tick2(3);
        vectors++; if (mmss !== 16'h0101) begin errors++; $display("FAIL run_ignores_2hz got=%h exp=%h", mmss, 16'h0101); end else $display("ok   run_ignores_2hz %h", mmss);
        tick1(3537);
        vectors++; if (mmss !== 16'h5958) begin errors++; $display("FAIL run_5958 got=%h exp=%h", mmss, 16'h5958); end else $display("ok   run_5958 %h", mmss);
        tick1(1);
        vectors++; if (mmss !== 16'h5959) begin errors++; $display("FAIL run_5959 got=%h exp=%h", mmss, 16'h5959); end else $display("ok   run_5959 %h", mmss);
        tick1(1);
        vectors++; if (mmss !== 16'h0000) begin errors++; $display("FAIL run_wrap got=%h exp=%h", mmss, 16'h0000); end else $display("ok   run_wrap %h", mmss);
    endtask

    task automatic test_pause();
        do_reset();
        tick1(5);
        press_pause();
        vectors++; if (sw_if.paused !== 1'b1) begin errors++; $display("FAIL pause_set got=%b exp=1", sw_if.paused); end else $display("ok   pause_set");
        tick1(3);
        vectors++; if (mmss !== 16'h0005) begin errors++; $display("FAIL pause_hold got=%h exp=%h", mmss, 16'h0005); end else $display("ok   pause_hold %h", mmss);
        press_pause();
        vectors++; if (sw_if.paused !== 1'b0) begin errors++; $display("FAIL pause_clear got=%b exp=0", sw_if.paused); end else $display("ok   pause_clear");
        tick1(2);
        vectors++; if (mmss !== 16'h0007) begin errors++; $display("FAIL pause_resume got=%h exp=%h", mmss, 16'h0007); end else $display("ok   pause_resume %h", mmss);
        // pause rise coinciding with a 1 Hz edge while running
        sw_if.pause_btn = 1; cyc(SS);
        sw_if.clk_1hz_in = 1; cyc(1);
        vectors++; if ({mmss, sw_if.paused} !== {16'h0008, 1'b1}) begin errors++; $display("FAIL pause_coinc_run got=%h/%b exp=0008/1", mmss, sw_if.paused); end else $display("ok   pause_coinc_run %h", mmss);
        sw_if.pause_btn = 0; sw_if.clk_1hz_in = 0; cyc(SS + 2);
        // pause rise coinciding with a 1 Hz edge while paused
        sw_if.pause_btn = 1; cyc(SS);
        sw_if.clk_1hz_in = 1; cyc(1);
        vectors++; if ({mmss, sw_if.paused} !== {16'h0008, 1'b0}) begin errors++; $display("FAIL pause_coinc_paused got=%h/%b exp=0008/0", mmss, sw_if.paused); end else $display("ok   pause_coinc_paused %h", mmss);
        sw_if.pause_btn = 0; sw_if.clk_1hz_in = 0; cyc(SS + 2);
        tick1(1);
        vectors++; if (mmss !== 16'h0009) begin errors++; $display("FAIL pause_after_coinc got=%h exp=%h", mmss, 16'h0009); end else $display("ok   pause_after_coinc %h", mmss);
    endtask

    task automatic test_adjust();
        do_reset();
        tick1(58);
        // adj_s rises in the same cycle as a 1 Hz edge: no run increment
        sw_if.adj = 1; sw_if.sel = 0; cyc(SS);
        sw_if.clk_1hz_in = 1; cyc(1);
        vectors++; if (mmss !== 16'h0058) begin errors++; $display("FAIL adj_entry_1hz got=%h exp=%h", mmss, 16'h0058); end else $display("ok   adj_entry_1hz %h", mmss);
        sw_if.clk_1hz_in = 0; cyc(1);
        vectors++; if (sw_if.blink_sec !== 1'b0) begin errors++; $display("FAIL adj_blink0 got=%b exp=0", sw_if.blink_sec); end else $display("ok   adj_blink0");
        tick2(1);
        vectors++; if ({mmss, sw_if.blink_sec, sw_if.blink_min} !== {16'h0059, 2'b10}) begin errors++; $display("FAIL adj_sec1 got=%h/%b%b exp=0059/10", mmss, sw_if.blink_sec, sw_if.blink_min); end else $display("ok   adj_sec1 %h", mmss);
        tick2(1);
        vectors++; if ({mmss, sw_if.blink_sec} !== {16'h0000, 1'b0}) begin errors++; $display("FAIL adj_sec2 got=%h/%b exp=0000/0", mmss, sw_if.blink_sec); end else $display("ok   adj_sec2 %h", mmss);
        tick2(1);
        vectors++; if ({mmss, sw_if.blink_sec} !== {16'h0001, 1'b1}) begin errors++; $display("FAIL adj_sec3 got=%h/%b exp=0001/1", mmss, sw_if.blink_sec); end else $display("ok   adj_sec3 %h", mmss);
        tick1(1);
        vectors++; if (mmss !== 16'h0001) begin errors++; $display("FAIL adj_ignores_1hz got=%h exp=%h", mmss, 16'h0001); end else $display("ok   adj_ignores_1hz %h", mmss);
        sw_if.sel = 1; cyc(SS + 1);
        vectors++; if ({sw_if.blink_min, sw_if.blink_sec} !== 2'b10) begin errors++; $display("FAIL adj_sel_blink got=%b%b exp=10", sw_if.blink_min, sw_if.blink_sec); end else $display("ok   adj_sel_blink");
        tick2(2);
        vectors++; if (mmss !== 16'h0201) begin errors++; $display("FAIL adj_min got=%h exp=%h", mmss, 16'h0201); end else $display("ok   adj_min %h", mmss);
        sw_if.clk_1hz_in = 1; sw_if.clk_2hz_in = 1; cyc(1);
        vectors++; if (mmss !== 16'h0301) begin errors++; $display("FAIL adj_both_edges got=%h exp=%h", mmss, 16'h0301); end else $display("ok   adj_both_edges %h", mmss);
        sw_if.clk_1hz_in = 0; sw_if.clk_2hz_in = 0; cyc(1);
    endtask

    task automatic test_adjust_pause();
        // continues from test_adjust: adj=1, sel=1, running, 03:01
        press_pause();
        vectors++; if (sw_if.paused !== 1'b0) begin errors++; $display("FAIL adjp_ignored got=%b exp=0", sw_if.paused); end else $display("ok   adjp_ignored");
        sw_if.adj = 0; cyc(SS + 1);
        vectors++; if ({sw_if.blink_min, sw_if.blink_sec, sw_if.paused} !== 3'b000) begin errors++; $display("FAIL adjp_exit_flags got=%b exp=000", {sw_if.blink_min, sw_if.blink_sec, sw_if.paused}); end else $display("ok   adjp_exit_flags");
        tick1(1);
        vectors++; if (mmss !== 16'h0302) begin errors++; $display("FAIL adjp_run_resume got=%h exp=%h", mmss, 16'h0302); end else $display("ok   adjp_run_resume %h", mmss);
        press_pause();
        sw_if.adj = 1; cyc(SS + 1);
        press_pause();
        vectors++; if (sw_if.paused !== 1'b1) begin errors++; $display("FAIL adjp_held got=%b exp=1", sw_if.paused); end else $display("ok   adjp_held");
        sw_if.adj = 0; cyc(SS + 1);
        tick1(2);
        vectors++; if ({mmss, sw_if.paused} !== {16'h0302, 1'b1}) begin errors++; $display("FAIL adjp_paused_resume got=%h/%b exp=0302/1", mmss, sw_if.paused); end else $display("ok   adjp_paused_resume %h", mmss);
    endtask

    task automatic test_reset_mid();
        do_reset();
        sw_if.adj = 1; sw_if.sel = 1; cyc(SS + 1);
        tick2(12);
        sw_if.sel = 0; cyc(SS + 1);
        tick2(34);
        sw_if.adj = 0; cyc(SS + 2);
        vectors++; if (mmss !== 16'h1234) begin errors++; $display("FAIL rstmid_setup got=%h exp=%h", mmss, 16'h1234); end else $display("ok   rstmid_setup %h", mmss);
        rst = 1; sw_if.clk_1hz_in = 1; cyc(1);
        vectors++; if (mmss !== 16'h0000) begin errors++; $display("FAIL rstmid_wins got=%h exp=%h", mmss, 16'h0000); end else $display("ok   rstmid_wins %h", mmss);
        rst = 0; cyc(3);
        vectors++; if (mmss !== 16'h0000) begin errors++; $display("FAIL rstmid_no_edge got=%h exp=%h", mmss, 16'h0000); end else $display("ok   rstmid_no_edge %h", mmss);
        sw_if.clk_1hz_in = 0; cyc(1);
        tick1(1);
        vectors++; if (mmss !== 16'h0001) begin errors++; $display("FAIL rstmid_next_tick got=%h exp=%h", mmss, 16'h0001); end else $display("ok   rstmid_next_tick %h", mmss);
    endtask

    initial begin
        test_reset();
        test_run_count();
        test_pause();
        test_adjust();
        test_adjust_pause();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
